mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-wide main-memory port between three requesters:
//  instruction-cache refill (read), data-cache refill (read) and store-buffer
//  writeback (write). Sits between cacheIns/dataCache/stb and memory.
//  Runs one transaction at a time: latches the winner's address and line,
//  drives memory until mem_done, then returns data/ack to the winner only.
// PARAMETERS
//  ARCH_BITS   32   address width
//  LINE_BITS   128  memory line width
//  OFF_BITS    4    line-offset bits; cleared in every address sent to memory
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset, synchronous, active-high
//  ic_req     in   1          icache refill request, held until ic_valid
//  ic_addr    in   ARCH_BITS  icache refill address
//  ic_line    out  LINE_BITS  refill line for icache
//  ic_valid   out  1          one-cycle pulse: ic_line valid
//  dc_req     in   1          dcache refill request, held until dc_valid
//  dc_addr    in   ARCH_BITS  dcache refill address
//  dc_line    out  LINE_BITS  refill line for dcache
//  dc_valid   out  1          one-cycle pulse: dc_line valid
//  wb_req     in   1          store-buffer writeback request, held until wb_ack
//  wb_addr    in   ARCH_BITS  writeback line address
//  wb_line    in   LINE_BITS  writeback data
//  wb_ack     out  1          one-cycle pulse: write committed
//  mem_req    out  1          memory transaction active
//  mem_we     out  1          1 = write, 0 = read; stable while mem_req
//  mem_addr   out  ARCH_BITS  line-aligned address; stable while mem_req
//  mem_wline  out  LINE_BITS  write data; stable while mem_req
//  mem_rline  in   LINE_BITS  read data, sampled when mem_done
//  mem_done   in   1          memory completion, one-cycle pulse
// BEHAVIOUR
//  - Reset: FSM=IDLE; mem_req, mem_we, ic_valid, dc_valid, wb_ack = 0;
//    mem_addr, mem_wline, ic_line, dc_line = 0; owner = none.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if any req, pick winner, latch addr (low OFF_BITS zeroed), we, wline;
//          next cycle in BUSY with mem_req=1. No req: stay IDLE.
//    BUSY: hold mem_* stable; on mem_done latch mem_rline into the winner's
//          line register, go RESP. mem_done in IDLE/RESP ignored.
//    RESP: drive exactly one of ic_valid/dc_valid/wb_ack for one cycle,
//          mem_req=0; go IDLE. Guarantees requester drops req before re-arb.
//  - Minimum turnaround: request->mem_req 1 cycle; mem_done->valid 1 cycle;
//    back-to-back grants separated by >=1 IDLE cycle.
//  - Fixed priority (default): dc > wb > ic. Simultaneous requests: highest
//    wins; losers stay pending, no state lost.
//  - Requester drops req while BUSY: transaction completes, response pulse
//    still issued; requester ignores it.
//  - ic_line/dc_line hold last value between pulses; only owner's updated.
//  - Reset mid-transaction: abandon immediately, all outputs to reset values;
//    memory must tolerate the withdrawn mem_req.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: rotating priority over {dc, wb, ic};
//    the granted requester becomes lowest priority for the next arbitration;
//    pointer resets to dc-highest.
//  Not defined: fixed priority dc > wb > ic, no pointer register.
// STRUCTURE
//  mem_arb_pkg: state encoding (IDLE/BUSY/RESP), requester ids
//    (REQ_DC=0, REQ_WB=1, REQ_IC=2, REQ_NONE), default widths.
//  Sub-module mem_arb_pick: combinational 3-way selector, inputs req vector
//    and rr pointer, outputs one-hot grant; pointer ignored when RR disabled.
// TESTING
//  1 ic_req, ic_addr=0x0000_1234; mem_done after 5 cyc, mem_rline=0xA5..A5
//    -> mem_addr=0x0000_1230, mem_we=0, one ic_valid pulse, ic_line=0xA5..A5.
//  2 dc_req+wb_req+ic_req same cycle (fixed) -> grants dc, wb, ic in order,
//    each followed by its own pulse; never two mem transactions overlap.
//  3 wb_req, wb_addr=0x40, wb_line=0x1122..FF -> mem_we=1, mem_wline stable
//    until mem_done, one wb_ack; no ic_valid/dc_valid.
//  4 rst asserted 2 cycles into BUSY -> next cycle mem_req=0, all pulses 0,
//    FSM IDLE; pending req re-granted after rst deasserts.
//  5 MEM_ARB_ROUND_ROBIN_EN, dc_req and ic_req held continuously -> grants
//    alternate dc, ic, dc, ic.
//  6 dc_req dropped mid-BUSY -> dc_valid pulse still issued; next grant normal.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, requester ids, default widths.
package mem_arb_pkg;

  localparam int unsigned DefArchBits = 32;
  localparam int unsigned DefLineBits = 128;
  localparam int unsigned DefOffBits  = 4;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  typedef enum logic [1:0] {
    ReqDc   = 2'd0,
    ReqWb   = 2'd1,
    ReqIc   = 2'd2,
    ReqNone = 2'd3
  } req_id_e;

  // Grant vector bit order matches the requester id: [0]=dc, [1]=wb, [2]=ic.
  function automatic req_id_e gnt_to_id(logic [2:0] gnt);
    case (gnt)
      3'b001:  return ReqDc;
      3'b010:  return ReqWb;
      3'b100:  return ReqIc;
      default: return ReqNone;
    endcase
  endfunction

  // The granted requester becomes lowest priority, so the next one up leads.
  function automatic req_id_e next_ptr(req_id_e win);
    case (win)
      ReqDc:   return ReqWb;
      ReqWb:   return ReqIc;
      default: return ReqDc;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of the arbiter; master = arbiter, slave = its environment.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ARCH_BITS = DefArchBits,
  parameter int unsigned LINE_BITS = DefLineBits
);

  logic                 ic_req;
  logic [ARCH_BITS-1:0] ic_addr;
  logic [LINE_BITS-1:0] ic_line;
  logic                 ic_valid;
  logic                 dc_req;
  logic [ARCH_BITS-1:0] dc_addr;
  logic [LINE_BITS-1:0] dc_line;
  logic                 dc_valid;
  logic                 wb_req;
  logic [ARCH_BITS-1:0] wb_addr;
  logic [LINE_BITS-1:0] wb_line;
  logic                 wb_ack;
  logic                 mem_req;
  logic                 mem_we;
  logic [ARCH_BITS-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_wline;
  logic [LINE_BITS-1:0] mem_rline;
  logic                 mem_done;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_addr, wb_req, wb_addr, wb_line, mem_rline, mem_done,
    output ic_line, ic_valid, dc_line, dc_valid, wb_ack, mem_req, mem_we, mem_addr, mem_wline
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_addr, wb_req, wb_addr, wb_line, mem_rline, mem_done,
    input  ic_line, ic_valid, dc_line, dc_valid, wb_ack, mem_req, mem_we, mem_addr, mem_wline
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational 3-way selector: one-hot grant starting from the requester named by ptr_i.
// With ptr_i tied to ReqDc this is plain fixed priority dc > wb > ic.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  req_id_e    ptr_i,
  output logic [2:0] gnt_o
);

  logic [2:0] rot_req;
  logic [2:0] rot_gnt;

  // Rotate so the highest-priority requester sits in bit 0, pick lowest set bit, rotate back.
  always_comb begin
    rot_req = req_i;
    gnt_o   = '0;
    case (ptr_i)
      ReqWb:   rot_req = {req_i[0], req_i[2:1]};
      ReqIc:   rot_req = {req_i[1:0], req_i[2]};
      default: rot_req = req_i;
    endcase

    if (rot_req[0])      rot_gnt = 3'b001;
    else if (rot_req[1]) rot_gnt = 3'b010;
    else if (rot_req[2]) rot_gnt = 3'b100;
    else                 rot_gnt = 3'b000;

    case (ptr_i)
      ReqWb:   gnt_o = {rot_gnt[1:0], rot_gnt[2]};
      ReqIc:   gnt_o = {rot_gnt[0], rot_gnt[2:1]};
      default: gnt_o = rot_gnt;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the line-wide memory port between icache, dcache and
// store-buffer writeback. Define MEM_ARB_ROUND_ROBIN_EN for rotating priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ARCH_BITS = DefArchBits,
  parameter int unsigned LINE_BITS = DefLineBits,
  parameter int unsigned OFF_BITS  = DefOffBits
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus_io
);

  state_e               state_q, state_d;
  req_id_e              owner_q, owner_d;
  logic                 mem_we_q, mem_we_d;
  logic [ARCH_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wline_q, mem_wline_d;
  logic [LINE_BITS-1:0] ic_line_q, ic_line_d;
  logic [LINE_BITS-1:0] dc_line_q, dc_line_d;

  logic [2:0]           req;
  logic [2:0]           gnt;
  req_id_e              ptr;
  req_id_e              win;
  logic [ARCH_BITS-1:0] win_addr;

  assign req = {bus_io.ic_req, bus_io.wb_req, bus_io.dc_req};

  mem_arb_pick u_pick (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );

  assign win = gnt_to_id(gnt);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && |req) ptr_d = next_ptr(win);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= ReqDc;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = ReqDc;
`endif

  always_comb begin
    case (win)
      ReqWb:   win_addr = bus_io.wb_addr;
      ReqIc:   win_addr = bus_io.ic_addr;
      default: win_addr = bus_io.dc_addr;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wline_d = mem_wline_q;
    ic_line_d   = ic_line_q;
    dc_line_d   = dc_line_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StBusy;
          owner_d     = win;
          mem_we_d    = (win == ReqWb);
          mem_addr_d  = {win_addr[ARCH_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
          mem_wline_d = (win == ReqWb) ? bus_io.wb_line : '0;
        end
      end
      StBusy: begin
        if (bus_io.mem_done) begin
          state_d = StResp;
          if (owner_q == ReqIc) ic_line_d = bus_io.mem_rline;
          if (owner_q == ReqDc) dc_line_d = bus_io.mem_rline;
        end
      end
      StResp: begin
        state_d = StIdle;
        owner_d = ReqNone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Synchronous reset also abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= ReqNone;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wline_q <= '0;
      ic_line_q   <= '0;
      dc_line_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wline_q <= mem_wline_d;
      ic_line_q   <= ic_line_d;
      dc_line_q   <= dc_line_d;
    end
  end

  assign bus_io.mem_req   = (state_q == StBusy);
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wline = mem_wline_q;
  assign bus_io.ic_line   = ic_line_q;
  assign bus_io.dc_line   = dc_line_q;
  assign bus_io.ic_valid  = (state_q == StResp) && (owner_q == ReqIc);
  assign bus_io.dc_valid  = (state_q == StResp) && (owner_q == ReqDc);
  assign bus_io.wb_ack    = (state_q == StResp) && (owner_q == ReqWb);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requesters and memory are modelled at transaction level.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the rotating-priority variant.
module tb_mem_arbiter;

  localparam int unsigned AB    = 32;
  localparam int unsigned LB    = 128;
  localparam int unsigned OB    = 4;
  localparam int          NCyc  = 4000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit          RrEn  = 1'b1;
`else
  localparam bit          RrEn  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ARCH_BITS(AB), .LINE_BITS(LB)) bus ();

  mem_arbiter #(.ARCH_BITS(AB), .LINE_BITS(LB), .OFF_BITS(OB)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester index: 0 = dc, 1 = wb, 2 = ic.
  logic          req_r   [3];
  logic [AB-1:0] addr_r  [3];
  bit            dropped [3];
  logic [LB-1:0] wline;
  logic          done;
  logic [LB-1:0] rline;

  // Priority rule: scan from the current leader upward, wrapping round the three ids.
  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic drive_bus();
    bus.dc_req    = req_r[0];
    bus.dc_addr   = addr_r[0];
    bus.wb_req    = req_r[1];
    bus.wb_addr   = addr_r[1];
    bus.wb_line   = wline;
    bus.ic_req    = req_r[2];
    bus.ic_addr   = addr_r[2];
    bus.mem_done  = done;
    bus.mem_rline = rline;
  endtask

  initial begin
    int            ptr, cur, mem_cnt;
    logic          p_rst, p_mreq, p_pulse, p_done;
    logic [2:0]    p_reqs, e_pulse, pulses;
    logic          e_mreq;
    logic [AB-1:0] cur_addr;
    logic          cur_we;
    logic [LB-1:0] cur_wline, cur_rline, exp_ic, exp_dc;

    for (int i = 0; i < 3; i++) begin
      req_r[i] = 1'b0; addr_r[i] = '0; dropped[i] = 1'b0;
    end
    wline = '0; done = 1'b0; rline = '0;
    drive_bus();
    ptr = 0; cur = -1; mem_cnt = -1;
    p_rst = 1'b1; p_mreq = 1'b0; p_pulse = 1'b0; p_done = 1'b0; p_reqs = '0;
    cur_addr = '0; cur_we = 1'b0; cur_wline = '0; cur_rline = '0; exp_ic = '0; exp_dc = '0;

    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk);
      pulses = {bus.ic_valid, bus.wb_ack, bus.dc_valid};
      e_pulse = '0;
      if (p_rst) begin
        e_mreq = 1'b0;
        exp_ic = '0;
        exp_dc = '0;
        ptr    = 0;
        cur    = -1;
        check("rst_mem_addr", LB'(bus.mem_addr), '0);
        check("rst_mem_we", LB'(bus.mem_we), '0);
        check("rst_mem_wline", bus.mem_wline, '0);
      end else begin
        // One transaction at a time; a grant needs an idle cycle after any response.
        e_mreq = (p_mreq && !p_done) || (!p_mreq && !p_pulse && (|p_reqs));
        if (p_mreq && p_done && cur >= 0) begin
          e_pulse[cur] = 1'b1;
          if (cur == 2) exp_ic = cur_rline;
          if (cur == 0) exp_dc = cur_rline;
        end
        if (e_mreq && !p_mreq) begin
          cur       = pick(p_reqs, ptr);
          if (RrEn) ptr = (cur + 1) % 3;
          cur_addr  = addr_r[cur] & ~AB'((1 << OB) - 1);
          cur_we    = (cur == 1);
          cur_wline = (cur == 1) ? wline : '0;
        end
      end

      check("mem_req", LB'(bus.mem_req), LB'(e_mreq));
      check("pulses_ic_wb_dc", LB'(pulses), LB'(e_pulse));
      check("ic_line", bus.ic_line, exp_ic);
      check("dc_line", bus.dc_line, exp_dc);
      if (e_mreq) begin
        check("mem_we", LB'(bus.mem_we), LB'(cur_we));
        check("mem_addr", LB'(bus.mem_addr), LB'(cur_addr));
        check("mem_wline", bus.mem_wline, cur_wline);
      end

      // Reset occasionally lands mid-transaction; the first few cycles are always reset.
      rst = (cyc < 3) || (e_mreq && $urandom_range(63) == 0);

      for (int i = 0; i < 3; i++) begin
        if (e_pulse[i]) begin
          req_r[i]   = 1'b0;
          dropped[i] = 1'b0;
        end else if (cyc == 3 || (!req_r[i] && !dropped[i] && $urandom_range(3) == 0)) begin
          if (!req_r[i]) begin
            req_r[i]  = 1'b1;
            addr_r[i] = $urandom();
            if (i == 1) wline = {$urandom(), $urandom(), $urandom(), $urandom()};
          end
        end else if (e_mreq && i == cur && req_r[i] && $urandom_range(15) == 0) begin
          req_r[i]   = 1'b0;
          dropped[i] = 1'b1;
        end
      end

      done = 1'b0;
      if (e_mreq) begin
        if (mem_cnt < 0) mem_cnt = $urandom_range(5);
        if (mem_cnt == 0) begin
          done      = 1'b1;
          rline     = {$urandom(), $urandom(), $urandom(), $urandom()};
          cur_rline = rline;
          mem_cnt   = -1;
        end else begin
          mem_cnt--;
        end
      end else if ($urandom_range(7) == 0) begin
        done  = 1'b1;
        rline = {$urandom(), $urandom(), $urandom(), $urandom()};
      end

      if (rst) begin
        mem_cnt = -1;
        for (int i = 0; i < 3; i++) dropped[i] = 1'b0;
      end

      p_rst   = rst;
      p_mreq  = e_mreq;
      p_pulse = |e_pulse;
      p_done  = done;
      p_reqs  = {req_r[2], req_r[1], req_r[0]};
      drive_bus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
